// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the register bank and the width-adapter stages.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [1:0] axil_resp_t;

  // Ceiling log2, used for byte-lane offset and register index widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < value; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_wr_join.sv
// AXI4-Lite write-address / write-data holding registers; emits one commit when both are held.
module axil_wr_join
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready_c,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready_c,
  input  logic                  bvalid,
  output logic                  commit_c,
  output logic [ADDR_WIDTH-1:0] commit_addr,
  output logic [DATA_WIDTH-1:0] commit_data
);

  logic aw_held;
  logic w_held;

  // Readies depend only on local state and reset, never on the incoming valids.
  assign awready_c = rstn && !aw_held && !bvalid;
  assign wready_c  = rstn && !w_held && !bvalid;
  assign commit_c  = aw_held && w_held;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_held     <= 1'b0;
      commit_addr <= '0;
    end else if (awvalid && awready_c) begin
      aw_held     <= 1'b1;
      commit_addr <= awaddr;
    end else if (commit_c) begin
      aw_held     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_held      <= 1'b0;
      commit_data <= '0;
    end else if (wvalid && wready_c) begin
      w_held      <= 1'b1;
      commit_data <= wdata;
    end else if (commit_c) begin
      w_held      <= 1'b0;
    end
  end

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite slave register bank: NUM_REGS full-word registers, flat readback vector and write strobes.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_stb
);

  localparam int unsigned ADDR_LSB = clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W    = clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  commit_c;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0] commit_data;
  logic                  awready_c;
  logic                  wready_c;
  logic                  bvalid;
  axil_resp_t            bresp;
  logic                  rvalid;
  axil_resp_t            rresp;
  logic [DATA_WIDTH-1:0] rdata;
  logic [NUM_REGS-1:0]   wr_stb;

  logic                  wr_ok_c;
  logic [IDX_W-1:0]      wr_idx_c;
  logic                  ar_hs_c;
  logic                  rd_ok_c;
  logic [IDX_W-1:0]      rd_idx_c;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> ADDR_LSB) < ADDR_WIDTH'(NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> ADDR_LSB);
  endfunction

  axil_wr_join #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_join (
    .clk         (clk),
    .rstn        (rstn),
    .awaddr      (s_axil_awaddr),
    .awvalid     (s_axil_awvalid),
    .awready_c   (awready_c),
    .wdata       (s_axil_wdata),
    .wvalid      (s_axil_wvalid),
    .wready_c    (wready_c),
    .bvalid      (bvalid),
    .commit_c    (commit_c),
    .commit_addr (commit_addr),
    .commit_data (commit_data)
  );

  assign wr_ok_c  = in_range(commit_addr);
  assign wr_idx_c = word_idx(commit_addr);
  assign ar_hs_c  = s_axil_arvalid && s_axil_arready;
  assign rd_ok_c  = in_range(s_axil_araddr);
  assign rd_idx_c = word_idx(s_axil_araddr);

  // Register array and write strobes; out-of-range commits leave the array untouched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wr_stb <= '0;
    end else begin
      wr_stb <= '0;
      if (commit_c && wr_ok_c) begin
        regs[wr_idx_c]   <= commit_data;
        wr_stb[wr_idx_c] <= 1'b1;
      end
    end
  end

  // Write response: held until the master takes it, which also blocks new AW/W.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else if (bvalid && s_axil_bready) begin
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else if (commit_c) begin
      bvalid <= 1'b1;
      bresp  <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read channel samples the array before any same-edge write lands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else if (ar_hs_c) begin
      rvalid <= 1'b1;
      rresp  <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
      rdata  <= rd_ok_c ? regs[rd_idx_c] : '0;
    end else if (rvalid && s_axil_rready) begin
      rvalid <= 1'b0;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
  end

  assign s_axil_awready = awready_c;
  assign s_axil_wready  = wready_c;
  assign s_axil_arready = rstn && !rvalid;
  assign s_axil_bvalid  = bvalid;
  assign s_axil_bresp   = bresp;
  assign s_axil_rvalid  = rvalid;
  assign s_axil_rresp   = rresp;
  assign s_axil_rdata   = rdata;
  assign reg_wr_stb     = wr_stb;

endmodule

// File: tb/tb_axil_regfile.sv
// Directed-vector bench for axil_regfile with hand-computed expectations.
module tb_axil_regfile;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [AW-1:0]    awaddr = '0;
  logic             awvalid = 1'b0;
  logic             awready;
  logic [DW-1:0]    wdata = '0;
  logic             wvalid = 1'b0;
  logic             wready;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready = 1'b0;
  logic [AW-1:0]    araddr = '0;
  logic             arvalid = 1'b0;
  logic             arready;
  logic [DW-1:0]    rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready = 1'b0;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]    reg_wr_stb;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_regs [NR];

  axil_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .s_axil_awaddr  (awaddr),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .reg_q          (reg_q),
    .reg_wr_stb     (reg_wr_stb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < int'(NR); i++) begin
      check($sformatf("%s reg_q[%0d]", tag, i), 64'(reg_q[i*DW +: DW]), 64'(exp_regs[i]));
    end
  endtask

  // AW and W in the same cycle with bready high; returns once bvalid is seen (bounded).
  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output logic [1:0] resp, output int lat);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 10) begin
      tick();
      lat++;
    end
    resp = bresp;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                          output logic [1:0] resp, output int lat);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 10) begin
      tick();
      lat++;
    end
    d = rdata;
    resp = rresp;
  endtask

  logic [1:0]    r;
  logic [DW-1:0] d;
  int            l;

  initial begin
    for (int i = 0; i < int'(NR); i++) exp_regs[i] = '0;

    // Reset state
    repeat (3) tick();
    check("rst awready", 64'(awready), 64'h0);
    check("rst bvalid", 64'(bvalid), 64'h0);
    check("rst rvalid", 64'(rvalid), 64'h0);
    check("rst stb", 64'(reg_wr_stb), 64'h0);
    check_regs("rst");
    rstn = 1'b1;
    tick();
    check("idle awready", 64'(awready), 64'h1);
    check("idle wready", 64'(wready), 64'h1);
    check("idle arready", 64'(arready), 64'h1);

    // A: same-cycle AW+W to 0x08, then read back
    axi_write(32'h08, 32'hDEADBEEF, r, l);
    exp_regs[2] = 32'hDEADBEEF;
    check("A bresp", 64'(r), 64'h0);
    check("A b latency", 64'(l), 64'h1);
    check("A stb", 64'(reg_wr_stb), 64'h0004);
    check("A awready busy", 64'(awready), 64'h0);
    check_regs("A");
    tick();
    check("A stb clear", 64'(reg_wr_stb), 64'h0);
    check("A bvalid clear", 64'(bvalid), 64'h0);
    axi_read(32'h08, d, r, l);
    check("A rdata", 64'(d), 64'hDEADBEEF);
    check("A rresp", 64'(r), 64'h0);
    check("A r latency", 64'(l), 64'h0);
    tick();
    check("A rvalid clear", 64'(rvalid), 64'h0);

    // B: W three edges ahead of AW
    wdata = 32'hA5A50003; wvalid = 1'b1; bready = 1'b1;
    tick();
    wvalid = 1'b0;
    check("B wready held", 64'(wready), 64'h0);
    check("B awready open", 64'(awready), 64'h1);
    tick();
    tick();
    check("B no early b", 64'(bvalid), 64'h0);
    awaddr = 32'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("B b after aw edge", 64'(bvalid), 64'h0);
    tick();
    exp_regs[3] = 32'hA5A50003;
    check("B bvalid", 64'(bvalid), 64'h1);
    check("B bresp", 64'(bresp), 64'h0);
    check("B stb", 64'(reg_wr_stb), 64'h0008);
    check_regs("B");
    tick();
    check("B bvalid clear", 64'(bvalid), 64'h0);
    tick();
    check("B single stb", 64'(reg_wr_stb), 64'h0);
    check("B single b", 64'(bvalid), 64'h0);

    // C: out-of-range write and read at 0x40
    axi_write(32'h40, 32'hFFFFFFFF, r, l);
    check("C bresp", 64'(r), 64'h2);
    check("C b latency", 64'(l), 64'h1);
    check("C stb", 64'(reg_wr_stb), 64'h0);
    check_regs("C");
    tick();
    axi_read(32'h40, d, r, l);
    check("C rresp", 64'(r), 64'h2);
    check("C rdata", 64'(d), 64'h0);
    tick();

    // D: bready held low for 10 cycles with a second AW pending
    awaddr = 32'h10; wdata = 32'h11110000; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    exp_regs[4] = 32'h11110000;
    check("D bvalid", 64'(bvalid), 64'h1);
    awaddr = 32'h14; awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("D stall%0d awready", i), 64'(awready), 64'h0);
      check($sformatf("D stall%0d wready", i), 64'(wready), 64'h0);
      check($sformatf("D stall%0d bvalid", i), 64'(bvalid), 64'h1);
      check($sformatf("D stall%0d bresp", i), 64'(bresp), 64'h0);
    end
    bready = 1'b1;
    tick();
    check("D bvalid clear", 64'(bvalid), 64'h0);
    check("D aw not on b edge", 64'(awready), 64'h1);
    tick();
    awvalid = 1'b0;
    check("D aw taken after b", 64'(awready), 64'h0);
    check("D wready open", 64'(wready), 64'h1);
    wdata = 32'h22220000; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    exp_regs[5] = 32'h22220000;
    check("D2 bvalid", 64'(bvalid), 64'h1);
    check("D2 stb", 64'(reg_wr_stb), 64'h0020);
    check_regs("D");
    tick();

    // E: read and write of 0x04 at the same edge
    axi_write(32'h04, 32'hCAFE0004, r, l);
    exp_regs[1] = 32'hCAFE0004;
    check("E0 bresp", 64'(r), 64'h0);
    tick();
    awaddr = 32'h04; wdata = 32'h12345678; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h04; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    exp_regs[1] = 32'h12345678;
    check("E rvalid", 64'(rvalid), 64'h1);
    check("E old rdata", 64'(rdata), 64'hCAFE0004);
    check("E bvalid", 64'(bvalid), 64'h1);
    check_regs("E");
    tick();
    axi_read(32'h04, d, r, l);
    check("E new rdata", 64'(d), 64'h12345678);
    tick();

    // F: reset with a held AW and an unaccepted read response
    rready = 1'b0;
    araddr = 32'h08; arvalid = 1'b1;
    awaddr = 32'h1C; awvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    check("F aw held", 64'(awready), 64'h0);
    check("F rvalid", 64'(rvalid), 64'h1);
    tick();
    tick();
    check("F rdata stable", 64'(rdata), 64'hDEADBEEF);
    check("F arready busy", 64'(arready), 64'h0);
    #2;
    rstn = 1'b0;
    #1;
    for (int i = 0; i < int'(NR); i++) exp_regs[i] = '0;
    check("F rst awready", 64'(awready), 64'h0);
    check("F rst wready", 64'(wready), 64'h0);
    check("F rst arready", 64'(arready), 64'h0);
    check("F rst bvalid", 64'(bvalid), 64'h0);
    check("F rst bresp", 64'(bresp), 64'h0);
    check("F rst rvalid", 64'(rvalid), 64'h0);
    check("F rst rresp", 64'(rresp), 64'h0);
    check("F rst rdata", 64'(rdata), 64'h0);
    check("F rst stb", 64'(reg_wr_stb), 64'h0);
    check_regs("F rst");
    tick();
    rstn = 1'b1;
    #1;
    check("F rel awready", 64'(awready), 64'h1);
    check("F rel arready", 64'(arready), 64'h1);
    axi_write(32'h1C, 32'h0BADF00D, r, l);
    exp_regs[7] = 32'h0BADF00D;
    check("F bresp", 64'(r), 64'h0);
    check("F b latency", 64'(l), 64'h1);
    check("F stb", 64'(reg_wr_stb), 64'h0080);
    check_regs("F");
    tick();
    axi_read(32'h1C, d, r, l);
    check("F rdata", 64'(d), 64'h0BADF00D);
    check("F rresp", 64'(r), 64'h0);
    tick();
    check("F rvalid clear", 64'(rvalid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
